// File: rtl/sch_serial_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/multiply controller.
// The controller and its per-bit slice both import this package.
package sch_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One slice produces a 2-bit add3 sum and a 2x2 unsigned product.
  localparam int SUM_W  = 2;
  localparam int PROD_W = 4;

endpackage

// File: rtl/sch_slice.sv
// One bit-slice of the add/multiply datapath: add3 of (a0, a1, carry),
// then {z, m2} * {m1, m0} as a 2b x 2b unsigned product.
module sch_slice
  import sch_serial_ctrl_pkg::*;
(
  input  logic              a0,
  input  logic              a1,
  input  logic              c,
  input  logic              m2,
  input  logic              m1,
  input  logic              m0,
  output logic              z,
  output logic              c_next,
  output logic [PROD_W-1:0] p
);

  logic [SUM_W-1:0]  s;
  logic [PROD_W-1:0] x;
  logic [PROD_W-1:0] y;

  assign s      = {1'b0, a0} + {1'b0, a1} + {1'b0, c};
  assign z      = s[0];
  assign c_next = s[1];

  assign x = PROD_W'({z, m2});
  assign y = PROD_W'({m1, m0});
  assign p = x * y;

endmodule

// File: rtl/sch_serial_ctrl.sv
// Bit-serial controller: runs one shared sch_slice over N steps, LSB first,
// with a valid/ready handshake on both the job input and the result output.
module sch_serial_ctrl
  import sch_serial_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] m2,
  input  logic [N-1:0] m1,
  input  logic [N-1:0] m0,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] mout3,
  output logic [N-1:0] mout2,
  output logic [N-1:0] mout1,
  output logic [N-1:0] mout0,
  output logic         cout,
  output logic         busy
);

  localparam int               CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic [N-1:0]     a0_q, a1_q, m2_q, m1_q, m0_q;
  logic [N-1:0]     r3_q, r2_q, r1_q, r0_q;

  logic              z;
  logic              c_next;
  logic [PROD_W-1:0] p;

  logic accept;
  logic drain;
  logic last_step;

  assign accept    = in_valid  && (state_q == IDLE);
  assign drain     = out_ready && (state_q == DONE);
  assign last_step = (state_q == RUN) && (cnt_q == LAST);

  // Operand registers shift right each step, so bit 0 is always the live slice input.
  sch_slice u_slice (
    .a0     (a0_q[0]),
    .a1     (a1_q[0]),
    .c      (carry_q),
    .m2     (m2_q[0]),
    .m1     (m1_q[0]),
    .m0     (m0_q[0]),
    .z      (z),
    .c_next (c_next),
    .p      (p)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (drain) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      m2_q    <= '0;
      m1_q    <= '0;
      m0_q    <= '0;
      r3_q    <= '0;
      r2_q    <= '0;
      r1_q    <= '0;
      r0_q    <= '0;
    end else if (accept) begin
      // Capture the whole job and wipe the previous result.
      a0_q    <= a0;
      a1_q    <= a1;
      m2_q    <= m2;
      m1_q    <= m1;
      m0_q    <= m0;
      carry_q <= cin;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      r3_q    <= '0;
      r2_q    <= '0;
      r1_q    <= '0;
      r0_q    <= '0;
    end else if (state_q == RUN) begin
      a0_q    <= a0_q >> 1;
      a1_q    <= a1_q >> 1;
      m2_q    <= m2_q >> 1;
      m1_q    <= m1_q >> 1;
      m0_q    <= m0_q >> 1;
      // Results enter at the MSB; after N steps the step-0 bit lands at bit 0.
      r3_q    <= {p[3], r3_q[N-1:1]};
      r2_q    <= {p[2], r2_q[N-1:1]};
      r1_q    <= {p[1], r1_q[N-1:1]};
      r0_q    <= {p[0], r0_q[N-1:1]};
      carry_q <= c_next;
      if (last_step) begin
        cout_q <= c_next;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign mout3 = r3_q;
  assign mout2 = r2_q;
  assign mout1 = r1_q;
  assign mout0 = r0_q;
  assign cout  = cout_q;

  a_status_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot({in_ready, busy, out_valid}));

  a_done_holds : assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable({mout3, mout2, mout1, mout0, cout}));

  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    busy |-> cnt_q <= LAST);

endmodule

// File: doc/sch_serial_ctrl.md
SCH_SERIAL_CTRL -- requirements
Module: sch_serial_ctrl

Interface
REQ-001 Parameter: N, default 4, operand width in bits and number of bit-serial steps per job (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  job request.
REQ-005 in_ready  output  1  controller can accept a job.
REQ-006 a1, a0, m2, m1, m0  input  N each  job operands, sampled on input handshake.
REQ-007 cin  input  1  carry-in, sampled on input handshake.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 mout3, mout2, mout1, mout0  output  N each  per-bit product result bits.
REQ-011 cout  output  1  final carry of the add chain.
REQ-012 busy  output  1  high in RUN state.

Function
REQ-013 The block SHALL compute, one bit-slice per clock on a single shared slice, the same result as the N-slice ripple add/multiply datapath.
REQ-014 For step i: s = a0[i] + a1[i] + c (2-bit); c_next = s[1]; z = s[0]; c at step 0 = cin.
REQ-015 For step i: P = {z, m2[i]} * {m1[i], m0[i]} (2b x 2b unsigned, 4-bit); mout3[i]=P[3], mout2[i]=P[2], mout1[i]=P[1], mout0[i]=P[0].
REQ-016 FSM states: IDLE, RUN, DONE; IDLE->RUN on in_valid & in_ready; RUN->DONE after step N-1; DONE->IDLE on out_valid & out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-018 On input handshake, all operands and cin SHALL be registered; later input changes SHALL NOT affect the job.
REQ-019 Step counter SHALL count 0..N-1 in RUN, one bit per cycle, LSB first; it SHALL clear on entry to RUN.
REQ-020 Latency: out_valid SHALL assert exactly N+1 cycles after the input handshake cycle.
REQ-021 In DONE, outputs SHALL hold stable until out_ready; out_ready low stalls indefinitely with no change.
REQ-022 A job offered in DONE (in_valid=1) SHALL NOT be accepted until the cycle after the output handshake; maximum throughput one job per N+2 cycles.
REQ-023 out_ready in IDLE or RUN SHALL be ignored; in_valid in RUN or DONE SHALL be ignored.
REQ-024 cout SHALL equal the carry out of step N-1, i.e. bit N of a0 + a1 + cin.
REQ-025 Result registers SHALL be cleared on entry to RUN, so no bits of a previous job remain.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, counter=0, carry=0, all result registers, cout, out_valid, busy = 0; in_ready = 1 the following cycle.
REQ-027 rst asserted in RUN or DONE SHALL abort the job with no out_valid pulse; rst has priority over every handshake in the same cycle.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the slice width constant (2-bit sum, 4-bit product).
REQ-029 One sub-module sch_slice SHALL implement the combinational per-bit add3 + 2x2 multiply (inputs a0, a1, c, m2, m1, m0 bits; outputs z, c_next, P[3:0]); the controller instantiates it once.

Verification
REQ-030 N=4, a0=5, a1=3, cin=0, m2=F, m1=0, m0=F, out_ready=1 -> out_valid 5 cycles after the handshake; mout0=F, mout1=8, mout2=0, mout3=0, cout=0.
REQ-031 N=4, a0=F, a1=1, cin=1, m2=F, m1=F, m0=F -> mout0=F, mout1=E, mout2=0, mout3=1, cout=1.
REQ-032 Backpressure: run REQ-030 with out_ready=0 for 10 cycles -> out_valid and results stable throughout, in_ready=0; on out_ready=1, one handshake, then IDLE.
REQ-033 Back-to-back: in_valid held high with two jobs (REQ-030 then REQ-031) -> second accepted exactly one cycle after the first output handshake; both results correct.
REQ-034 Reset mid-RUN at step 2 -> next cycle IDLE, in_ready=1, outputs 0, no out_valid; a following REQ-031 job completes correctly.
REQ-035 Randomised compare over 1000 jobs against a reference model of REQ-014/REQ-015 -> zero mismatches.
